// File: rtl/vpe_pipe_array.sv
// vpe_pipe_array: per-lane vector multiply-add or dot-product-plus-scalar; VPE_VEC_SAT_EN selects saturating vector results.
// Latency: LAT = 2+log2(TILE_SIZE) cycles from accept to output; throughput one transaction per cycle.
// Backpressure: a stalled output freezes every stage (bubbles included); in_ready_o = ~out_valid_o | out_ready_i.
module vpe_pipe_array #(
    parameter int  NUM_LANES = 3,
    parameter int  TILE_SIZE = 128,
    parameter int  DATA_W    = 16,
    localparam int LOG_T     = $clog2(TILE_SIZE),
    localparam int ACC_W     = 2*DATA_W + LOG_T + 1,
    localparam int LAT       = 2 + LOG_T
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 in_valid_i,
    output logic                                 in_ready_o,
    input  logic [NUM_LANES*TILE_SIZE*DATA_W-1:0] operand1_i,
    input  logic [NUM_LANES*TILE_SIZE*DATA_W-1:0] operand2_i,
    input  logic [NUM_LANES*DATA_W-1:0]           operand3_i,
    input  logic [NUM_LANES-1:0]                  mode_i,
    output logic                                 out_valid_o,
    input  logic                                 out_ready_i,
    output logic [NUM_LANES*TILE_SIZE*DATA_W-1:0] Vec_o,
    output logic [NUM_LANES*ACC_W-1:0]            Scal_o,
    output logic [NUM_LANES-1:0]                  mode_o
`ifdef VPE_VEC_SAT_EN
    ,
    output logic [NUM_LANES-1:0]                  sat_flag_o
`endif
);

    localparam int PW = 2*DATA_W;
    localparam int VW = TILE_SIZE*DATA_W;

    logic                 advance;
    logic [LAT-1:0]       vld_q;
    logic [NUM_LANES-1:0] mode_q [LAT];

    assign advance     = ~vld_q[LAT-1] | out_ready_i;
    assign in_ready_o  = advance;
    assign out_valid_o = vld_q[LAT-1];
    assign mode_o      = mode_q[LAT-1];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q <= '0;
            for (int k = 0; k < LAT; k++) mode_q[k] <= '0;
        end else if (advance) begin
            vld_q     <= {vld_q[LAT-2:0], in_valid_i};
            mode_q[0] <= mode_i;
            for (int k = 1; k < LAT; k++) mode_q[k] <= mode_q[k-1];
        end
    end

    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        logic signed [DATA_W-1:0] a0     [TILE_SIZE];
        logic signed [DATA_W-1:0] b0     [TILE_SIZE];
        logic signed [DATA_W-1:0] c_q    [LAT-1];
        logic signed [PW-1:0]     prod_c [TILE_SIZE];
        logic signed [PW-1:0]     p1     [TILE_SIZE];
        logic [VW-1:0]            vec_c;
        logic [VW-1:0]            v_q    [1:LAT-2];
        logic signed [ACC_W-1:0]  tree_q [LOG_T > 1 ? LOG_T-1 : 1][TILE_SIZE/2];
        logic signed [ACC_W-1:0]  ra;
        logic signed [ACC_W-1:0]  rb;
        logic [VW-1:0]            vec_out;
        logic signed [ACC_W-1:0]  scal_out;

`ifdef VPE_VEC_SAT_EN
        localparam int FW = PW + 1;
        localparam logic signed [FW-1:0] VMAX = FW'((2**(DATA_W-1)) - 1);
        localparam logic signed [FW-1:0] VMIN = FW'(-(2**(DATA_W-1)));
        logic signed [FW-1:0] full_c [TILE_SIZE];
        logic                 sat_c;
        logic                 f_q [1:LAT-2];
        logic                 flag_out;

        always_comb begin
            vec_c = '0;
            sat_c = 1'b0;
            for (int e = 0; e < TILE_SIZE; e++) begin
                prod_c[e] = PW'(a0[e]) * PW'(b0[e]);
                full_c[e] = FW'(prod_c[e]) + FW'(c_q[0]);
                if (full_c[e] > VMAX) begin
                    vec_c[e*DATA_W +: DATA_W] = VMAX[DATA_W-1:0];
                    sat_c = 1'b1;
                end else if (full_c[e] < VMIN) begin
                    vec_c[e*DATA_W +: DATA_W] = VMIN[DATA_W-1:0];
                    sat_c = 1'b1;
                end else begin
                    vec_c[e*DATA_W +: DATA_W] = full_c[e][DATA_W-1:0];
                end
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                flag_out <= 1'b0;
            end else if (advance) begin
                f_q[1] <= sat_c;
                for (int k = 2; k <= LAT-2; k++) f_q[k] <= f_q[k-1];
                flag_out <= mode_q[LAT-2][l] ? 1'b0 : f_q[LAT-2];
            end
        end

        assign sat_flag_o[l] = flag_out;
`else
        always_comb begin
            vec_c = '0;
            for (int e = 0; e < TILE_SIZE; e++) begin
                prod_c[e] = PW'(a0[e]) * PW'(b0[e]);
                vec_c[e*DATA_W +: DATA_W] = prod_c[e][DATA_W-1:0] + c_q[0];
            end
        end
`endif

        // S0 input capture, S1 products, then the registered tree levels below the root.
        always_ff @(posedge clk_i) begin
            if (advance) begin
                for (int e = 0; e < TILE_SIZE; e++) begin
                    a0[e] <= operand1_i[(l*TILE_SIZE+e)*DATA_W +: DATA_W];
                    b0[e] <= operand2_i[(l*TILE_SIZE+e)*DATA_W +: DATA_W];
                    p1[e] <= prod_c[e];
                end
                c_q[0] <= operand3_i[l*DATA_W +: DATA_W];
                for (int k = 1; k <= LAT-2; k++) c_q[k] <= c_q[k-1];
                v_q[1] <= vec_c;
                for (int k = 2; k <= LAT-2; k++) v_q[k] <= v_q[k-1];
                for (int lv = 0; lv < LOG_T-1; lv++) begin
                    for (int i = 0; i < TILE_SIZE/2; i++) begin
                        if (i < (TILE_SIZE >> (lv+1))) begin
                            if (lv == 0)
                                tree_q[lv][i] <= ACC_W'(p1[2*i]) + ACC_W'(p1[2*i+1]);
                            else
                                tree_q[lv][i] <= tree_q[lv-1][2*i] + tree_q[lv-1][2*i+1];
                        end
                    end
                end
            end
        end

        if (LOG_T == 1) begin : g_root_leaf
            assign ra = ACC_W'(p1[0]);
            assign rb = ACC_W'(p1[1]);
        end else begin : g_root_tree
            assign ra = tree_q[LOG_T-2][0];
            assign rb = tree_q[LOG_T-2][1];
        end

        // Root adder doubles as the output register; the unused result of each mode is forced to zero.
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                vec_out  <= '0;
                scal_out <= '0;
            end else if (advance) begin
                if (mode_q[LAT-2][l]) begin
                    vec_out  <= '0;
                    scal_out <= ra + rb + ACC_W'(c_q[LAT-2]);
                end else begin
                    vec_out  <= v_q[LAT-2];
                    scal_out <= '0;
                end
            end
        end

        assign Vec_o[l*VW +: VW]        = vec_out;
        assign Scal_o[l*ACC_W +: ACC_W] = scal_out;
    end

endmodule
